// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: default widths and status struct shared by the FIFO slice
package jtag_types_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous read
module param_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: parameterised FIFO with registered or first-word-fall-through read
module param_fifo
  import jtag_types_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT = 1'b0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     winc,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     rinc,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_T = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_T = (AW+1)'(AE_THRESH);
  logic [AW:0] wptr, rptr, cnt;
  logic [DATA_WIDTH-1:0] head, rdata_q;
  logic ovf_q, udf_q, push, pop;
  fifo_status_t st;
  assign cnt = wptr - rptr;
  always_comb begin
    st.empty = wptr == rptr;
    st.full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    st.almost_full = cnt >= AF_T;
    st.almost_empty = cnt <= AE_T;
    st.overflow = ovf_q;
    st.underflow = udf_q;
  end
  assign push = winc & ~st.full & ~flush;
  assign pop = rinc & ~st.empty & ~flush;
  param_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wptr[AW-1:0]),
    .wdata(wdata),
    .raddr(rptr[AW-1:0]),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      wptr <= '0;
      rptr <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      rdata_q <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr <= wptr + {{AW{1'b0}}, push};
      rptr <= rptr + {{AW{1'b0}}, pop};
      ovf_q <= ovf_q | (winc & st.full);
      udf_q <= udf_q | (rinc & st.empty);
      if (pop && !FWFT) rdata_q <= head;
    end
  assign rdata = FWFT ? (st.empty ? '0 : head) : rdata_q;
  assign {full, empty, almost_full, almost_empty, overflow, underflow} = st;
  assign count = cnt;
endmodule
